cam_match_reader: RTL
=====================

CAM_MATCH_READER -- requirements
Module: cam_match_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: word width of one CAM row.
REQ-002 SHALL have parameter DATA_DEPTH, default 16: number of CAM rows (tag bits).
REQ-003 SHALL have parameter ADDR_WIDTH_CAM, default 8: row address width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstIn, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle request to read out all rows tagged in the current match.
REQ-007 SHALL have port tag_row, input, DATA_DEPTH: per-row match tags from the cell array; bit i set means row i matched.
REQ-008 SHALL have port Q_out_row, input, DATA_WIDTH: row read data returned by the array for addr_output_Row.
REQ-009 SHALL have port addr_output_Row, output, ADDR_WIDTH_CAM: row read address driven to the array.
REQ-010 SHALL have port out_data, output, DATA_WIDTH: matched row contents.
REQ-011 SHALL have port out_addr, output, ADDR_WIDTH_CAM: row index of out_data.
REQ-012 SHALL have port out_valid, output, 1, and port out_ready, input, 1: output handshake.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse at the end of a readout.
REQ-015 SHALL have port match_count, output, ADDR_WIDTH_CAM+1: number of rows transferred in the last or current readout.

Function
REQ-016 SHALL implement the FSM states IDLE, SCAN, READ, OUT and DONE.
REQ-017 IDLE: start=1 SHALL snapshot tag_row into a pending mask, clear match_count, and go to SCAN; later changes on tag_row SHALL NOT affect the readout.
REQ-018 SCAN: pending=0 SHALL go to DONE; otherwise the FSM SHALL drive addr_output_Row with the lowest set pending index, zero-extended, and go to READ.
REQ-019 READ: the FSM SHALL capture Q_out_row into out_data and the index into out_addr, clear that pending bit, and go to OUT.
REQ-020 OUT: out_valid SHALL be 1, with out_data and out_addr held stable until out_valid and out_ready are both 1 at a rising edge; then the FSM SHALL increment match_count and go to SCAN.
REQ-021 out_ready SHALL be ignored outside OUT.
REQ-022 DONE: done SHALL be 1 for exactly one cycle, and the FSM SHALL then go to IDLE.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 Latency: with start high in cycle 0, out_valid SHALL first rise in cycle 3.
REQ-025 Each further match SHALL take 3 cycles when out_ready is held high.
REQ-026 With zero matches, done SHALL be high in cycle 2 and out_valid SHALL never rise.
REQ-027 Rows SHALL be emitted in ascending index order, each exactly once.
REQ-028 addr_output_Row SHALL hold its last value outside SCAN and READ.

Reset
REQ-029 rstIn=1 SHALL immediately force IDLE at any time, including mid-readout.
REQ-030 rstIn=1 SHALL clear the pending mask and drive out_valid=0, done=0, busy=0, out_data=0, out_addr=0, addr_output_Row=0 and match_count=0.
REQ-031 After rstIn is released, the block SHALL do nothing until the next start; no partial transfer SHALL resume.

Configuration
REQ-032 Macro CAM_READER_COUNT_EN defined: the match_count counter SHALL be built and SHALL behave as in REQ-017 and REQ-020.
REQ-033 Macro CAM_READER_COUNT_EN undefined: the match_count port SHALL remain present, tied to 0, with no counter logic built.

Structure
REQ-034 The FSM state encoding and default parameter constants SHALL live in the shared package cam_pkg.
REQ-035 The lowest-set-bit priority encoder SHALL be the sub-module cam_prio_enc: DATA_DEPTH-bit input, index output, any-set flag output, purely combinational.

Verification
REQ-036 The bench SHALL cover: tag_row=16'h0000, start -> done in cycle 2, no out_valid, match_count=0.
REQ-037 The bench SHALL cover: tag_row=16'h8421, out_ready=1 -> out_addr 0,5,10,15 with matching row data, first out_valid in cycle 3, then every 3 cycles, match_count=4.
REQ-038 The bench SHALL cover: tag_row=16'h0006, out_ready low for 5 cycles during OUT -> out_data and out_addr stable at row 1, then rows 1 and 2 delivered exactly once.
REQ-039 The bench SHALL cover: start pulsed again while busy, and tag_row changed after start -> second start ignored, emitted rows follow the original snapshot.
REQ-040 The bench SHALL cover: rstIn asserted in OUT for tag_row=16'hFFFF -> outputs zero asynchronously, busy=0; new start with 16'h0001 -> only row 0 delivered.
REQ-041 The bench SHALL cover: build without CAM_READER_COUNT_EN, tag_row=16'h00FF -> 8 transfers, match_count stays 0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the CAM match reader: FSM state encoding and default sizes.
package cam_pkg;

  localparam int CAM_DATA_WIDTH = 8;
  localparam int CAM_DATA_DEPTH = 16;
  localparam int CAM_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_READ = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } cam_state_t;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest set bit of i_vec plus an any-set flag.
module cam_prio_enc #(
  parameter int WIDTH = 16,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx = {IDX_W{1'b0}};
    o_any = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      o_idx = i_vec[i] ? IDX_W'(i) : o_idx;
      o_any = i_vec[i] | o_any;
    end
  end

endmodule

// File: rtl/cam_match_reader.sv
// Reads out every CAM row tagged in a snapshot of tag_row, lowest index first, over a valid/ready port.
// Optional feature: define CAM_READER_COUNT_EN to build the match_count transfer counter.
module cam_match_reader
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH     = CAM_DATA_WIDTH,
  parameter int DATA_DEPTH     = CAM_DATA_DEPTH,
  parameter int ADDR_WIDTH_CAM = CAM_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rstIn,
  input  logic                      start,
  input  logic [DATA_DEPTH-1:0]     tag_row,
  input  logic [DATA_WIDTH-1:0]     Q_out_row,
  output logic [ADDR_WIDTH_CAM-1:0] addr_output_Row,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [ADDR_WIDTH_CAM-1:0] out_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_WIDTH_CAM:0]   match_count
);

  localparam int IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

  cam_state_t                r_state;
  cam_state_t                w_state_nxt;
  logic [DATA_DEPTH-1:0]     r_pending;
  logic [IDX_W-1:0]          r_idx;
  logic [IDX_W-1:0]          w_idx;
  logic                      w_any;
  logic [ADDR_WIDTH_CAM-1:0] r_addr_row;
  logic [DATA_WIDTH-1:0]     r_out_data;
  logic [ADDR_WIDTH_CAM-1:0] r_out_addr;
  logic                      r_out_valid;
  logic                      r_busy;
  logic                      r_done;

  cam_prio_enc #(
    .WIDTH (DATA_DEPTH),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .i_vec (r_pending),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // State register.
  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE and out_ready only in OUT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SCAN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (w_any) begin
          w_state_nxt = ST_READ;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_READ: w_state_nxt = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          w_state_nxt = ST_SCAN;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: snapshot, row addressing, output capture and registered status flags.
  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      r_pending   <= {DATA_DEPTH{1'b0}};
      r_idx       <= {IDX_W{1'b0}};
      r_addr_row  <= {ADDR_WIDTH_CAM{1'b0}};
      r_out_data  <= {DATA_WIDTH{1'b0}};
      r_out_addr  <= {ADDR_WIDTH_CAM{1'b0}};
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pending <= tag_row;
          end
        end
        ST_SCAN: begin
          if (w_any) begin
            r_idx      <= w_idx;
            r_addr_row <= ADDR_WIDTH_CAM'(w_idx);
          end
        end
        ST_READ: begin
          r_out_data         <= Q_out_row;
          r_out_addr         <= r_addr_row;
          r_pending[r_idx]   <= 1'b0;
        end
        default: begin
        end
      endcase
      r_out_valid <= (w_state_nxt == ST_OUT);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

`ifdef CAM_READER_COUNT_EN
  logic [ADDR_WIDTH_CAM:0] r_match_count;

  // Transfer counter: cleared on an accepted start, bumped on each completed handshake.
  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      r_match_count <= {(ADDR_WIDTH_CAM+1){1'b0}};
    end else if ((r_state == ST_IDLE) && start) begin
      r_match_count <= {(ADDR_WIDTH_CAM+1){1'b0}};
    end else if ((r_state == ST_OUT) && out_ready) begin
      r_match_count <= r_match_count + {{ADDR_WIDTH_CAM{1'b0}}, 1'b1};
    end
  end

  assign match_count = r_match_count;
`else
  assign match_count = {(ADDR_WIDTH_CAM+1){1'b0}};
`endif

  assign addr_output_Row = r_addr_row;
  assign out_data        = r_out_data;
  assign out_addr        = r_out_addr;
  assign out_valid       = r_out_valid;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule
